// File: rtl/find_range_if.sv
// Handshake and result bus of the find_range search engine.
// master drives the range and start/abort; slave returns status and the best result.
interface find_range_if #(
  parameter int unsigned SEQ_WIDTH   = 8,
  parameter int unsigned E_WIDTH     = 20,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   i_start;
  logic                   i_abort;
  logic [SEQ_WIDTH-1:0]   i_first;
  logic [SEQ_WIDTH-1:0]   i_last;
  logic                   o_busy;
  logic                   o_done;
  logic [SEQ_WIDTH-1:0]   o_seq;
  logic [E_WIDTH-1:0]     o_e;
  logic [COUNT_WIDTH-1:0] o_count;

  modport master (
    output i_start, i_abort, i_first, i_last,
    input  o_busy, o_done, o_seq, o_e, o_count
  );

  modport slave (
    input  i_start, i_abort, i_first, i_last,
    output o_busy, o_done, o_seq, o_e, o_count
  );
endinterface

// File: rtl/find_range.sv
// Range search for low-autocorrelation binary sequences, one autocorrelation lag per cycle.
// Define FIND_SYM_SKIP_EN to skip sequences with MSB set (complement symmetry).
module find_range #(
  parameter int unsigned SEQ_WIDTH   = 8,
  parameter int unsigned E_WIDTH     = 20,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  find_range_if.slave   bus
);

  localparam int unsigned KW  = $clog2(SEQ_WIDTH);
  // Signed lag sum spans -(N-1)..(N-1); two extra bits cover the 2*d term without wrap.
  localparam int unsigned CW  = KW + 2;
  localparam int unsigned SQW = 2 * CW;

  typedef enum logic [1:0] {StIdle, StCalc, StCmp, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SEQ_WIDTH-1:0]   seq_q, last_q, best_seq_q;
  logic [KW-1:0]          k_q;
  logic [E_WIDTH-1:0]     acc_q, best_e_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   accept, abort_eff, last_lag, seq_end;
  logic                   skip_first, skip_next, skip_cur;
  logic [SEQ_WIDTH-1:0]   seq_inc, diff;
  logic [CW-1:0]          d, c_raw, c_mag;
  logic [SQW-1:0]         c_sq;

  // Lag k term: count disagreeing pairs, turn into C_k and square it.
  always_comb begin
    diff = seq_q ^ (seq_q >> k_q);
    d    = '0;
    for (int unsigned i = 0; i < SEQ_WIDTH; i++) begin
      if (i < SEQ_WIDTH - 32'(k_q)) d = d + CW'(diff[i]);
    end
    c_raw = CW'(SEQ_WIDTH) - CW'(k_q) - (d << 1);
    c_mag = c_raw[CW-1] ? (~c_raw + CW'(1)) : c_raw;
    c_sq  = SQW'(c_mag) * SQW'(c_mag);
  end

  always_comb begin
    accept    = (state_q == StIdle) && bus.i_start;
    abort_eff = bus.i_abort && ((state_q == StCalc) || (state_q == StCmp));
    last_lag  = (k_q == KW'(SEQ_WIDTH - 1));
    seq_end   = (seq_q == last_q);
    seq_inc   = seq_q + SEQ_WIDTH'(1);
`ifdef FIND_SYM_SKIP_EN
    skip_first = bus.i_first[SEQ_WIDTH-1];
    skip_next  = seq_inc[SEQ_WIDTH-1];
    skip_cur   = seq_q[SEQ_WIDTH-1];
`else
    skip_first = 1'b0;
    skip_next  = 1'b0;
    skip_cur   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          if (bus.i_first > bus.i_last) state_d = StDone;
          else                          state_d = skip_first ? StCmp : StCalc;
        end
      end
      StCalc: begin
        if (bus.i_abort)   state_d = StIdle;
        else if (last_lag) state_d = StCmp;
      end
      StCmp: begin
        if (bus.i_abort)  state_d = StIdle;
        else if (seq_end) state_d = StDone;
        else              state_d = skip_next ? StCmp : StCalc;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q      <= '0;
      last_q     <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      best_e_q   <= '1;
      best_seq_q <= '0;
      count_q    <= '0;
    end else if (accept) begin
      seq_q      <= bus.i_first;
      last_q     <= bus.i_last;
      k_q        <= KW'(1);
      acc_q      <= '0;
      best_e_q   <= '1;
      best_seq_q <= '0;
      count_q    <= '0;
    end else if (!abort_eff) begin
      if (state_q == StCalc) begin
        acc_q <= acc_q + E_WIDTH'(c_sq);
        k_q   <= k_q + KW'(1);
      end
      if (state_q == StCmp) begin
        if (!skip_cur) begin
          if (acc_q < best_e_q) begin
            best_e_q   <= acc_q;
            best_seq_q <= seq_q;
            count_q    <= COUNT_WIDTH'(1);
          end else if ((acc_q == best_e_q) && (count_q != '1)) begin
            count_q <= count_q + COUNT_WIDTH'(1);
          end
        end
        // Compare before increment so i_last = all-ones terminates without wrapping.
        if (!seq_end) begin
          seq_q <= seq_inc;
          k_q   <= KW'(1);
          acc_q <= '0;
        end
      end
    end
  end

  always_comb begin
    bus.o_busy  = (state_q != StIdle);
    bus.o_done  = (state_q == StDone);
    bus.o_seq   = best_seq_q;
    bus.o_e     = best_e_q;
    bus.o_count = count_q;
  end

endmodule

// File: tb/tb_find_range.sv
// Bench for find_range: an N=3 and an N=5 instance driven from one initial block,
// expected results come from a +/-1 energy model pushed into a scoreboard queue.
module tb_find_range;

`ifdef FIND_SYM_SKIP_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif
  localparam logic [31:0] EOnes = 32'h000F_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  find_range_if #(.SEQ_WIDTH(3), .E_WIDTH(20), .COUNT_WIDTH(16)) bus3 ();
  find_range_if #(.SEQ_WIDTH(5), .E_WIDTH(20), .COUNT_WIDTH(16)) bus5 ();

  find_range #(.SEQ_WIDTH(3), .E_WIDTH(20), .COUNT_WIDTH(16)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  find_range #(.SEQ_WIDTH(5), .E_WIDTH(20), .COUNT_WIDTH(16)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  typedef struct {
    logic [31:0] e;
    logic [31:0] seq;
    logic [31:0] count;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] e;
    logic [31:0] seq;
    logic [31:0] count;
    int          lat;
    logic        busy_at_done;
    logic        done_after;
    logic        busy_after;
  } obs_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int energy(input int n, input int s);
    int e = 0;
    for (int k = 1; k < n; k++) begin
      int c = 0;
      for (int i = 0; i < n - k; i++) begin
        int si = ((s >> i) & 1) != 0 ? -1 : 1;
        int sj = ((s >> (i + k)) & 1) != 0 ? -1 : 1;
        c += si * sj;
      end
      e += c * c;
    end
    return e;
  endfunction

  function automatic exp_t model(input int n, input int first, input int last);
    exp_t x;
    int   cyc = 0;
    x.e = EOnes; x.seq = '0; x.count = '0;
    if (first > last) begin
      x.lat = 1;
    end else begin
      for (int s = first; s <= last; s++) begin
        if (SkipEn && (((s >> (n - 1)) & 1) != 0)) begin
          cyc += 1;
        end else begin
          int en = energy(n, s);
          cyc += n;
          if (en < int'(x.e)) begin
            x.e = en; x.seq = s; x.count = 1;
          end else if (en == int'(x.e)) begin
            x.count = x.count + 1;
          end
        end
      end
      x.lat = cyc + 1;
    end
    return x;
  endfunction

  // Starts a search; lat counts negedges after the start edge until o_done is seen (-1: none).
  task automatic run(input bit use5, input int first, input int last, input int inject_at,
                     input int abort_at, input int budget, output obs_t o);
    logic done_now;
    o = '{e: 'x, seq: 'x, count: 'x, lat: -1, busy_at_done: 'x, done_after: 'x, busy_after: 'x};
    @(negedge clk);
    if (use5) begin
      bus5.i_first = 5'(first); bus5.i_last = 5'(last); bus5.i_start = 1'b1;
    end else begin
      bus3.i_first = 3'(first); bus3.i_last = 3'(last); bus3.i_start = 1'b1;
    end
    if (abort_at < 0) sb.push_back(model(use5 ? 5 : 3, first, last));
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus3.i_start = 1'b0; bus5.i_start = 1'b0; bus3.i_abort = 1'b0; bus5.i_abort = 1'b0;
      if (c == inject_at) begin
        if (use5) begin bus5.i_first = '0; bus5.i_last = '0; bus5.i_start = 1'b1; end
        else      begin bus3.i_first = '0; bus3.i_last = '0; bus3.i_start = 1'b1; end
      end
      if (c == abort_at) begin
        if (use5) bus5.i_abort = 1'b1;
        else      bus3.i_abort = 1'b1;
      end
      done_now = use5 ? bus5.o_done : bus3.o_done;
      if (done_now === 1'b1) begin
        o.lat          = c;
        o.e            = use5 ? 32'(bus5.o_e) : 32'(bus3.o_e);
        o.seq          = use5 ? 32'(bus5.o_seq) : 32'(bus3.o_seq);
        o.count        = use5 ? 32'(bus5.o_count) : 32'(bus3.o_count);
        o.busy_at_done = use5 ? bus5.o_busy : bus3.o_busy;
        @(negedge clk);
        bus3.i_start = 1'b0; bus5.i_start = 1'b0;
        o.done_after   = use5 ? bus5.o_done : bus3.o_done;
        o.busy_after   = use5 ? bus5.o_busy : bus3.o_busy;
        break;
      end
    end
    bus3.i_start = 1'b0; bus5.i_start = 1'b0; bus3.i_abort = 1'b0; bus5.i_abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus3.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset busy: got %b want 0", bus3.o_busy); end
    n_tests++; if (bus3.o_done !== 1'b0) begin n_fail++;
      $display("FAIL reset done: got %b want 0", bus3.o_done); end
    n_tests++; if (bus3.o_seq !== 3'd0) begin n_fail++;
      $display("FAIL reset seq: got %0d want 0", bus3.o_seq); end
    n_tests++; if (32'(bus3.o_e) !== EOnes) begin n_fail++;
      $display("FAIL reset e: got %0h want %0h", bus3.o_e, EOnes); end
    n_tests++; if (bus3.o_count !== 16'd0) begin n_fail++;
      $display("FAIL reset count: got %0d want 0", bus3.o_count); end
    n_tests++; if (32'(bus5.o_e) !== EOnes || bus5.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL reset n5: got e=%0h busy=%b want e=%0h busy=0", bus5.o_e, bus5.o_busy, EOnes);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Full range, single top sequence, empty range and two sub-ranges on N=3.
  task automatic test_ranges3;
    int   firsts [5] = '{0, 7, 5, 3, 2};
    int   lasts  [5] = '{7, 7, 2, 6, 2};
    obs_t o;
    exp_t x;
    for (int t = 0; t < 5; t++) begin
      run(1'b0, firsts[t], lasts[t], -1, -1, 200, o);
      x = sb.pop_front();
      n_tests++; if (o.lat !== x.lat) begin n_fail++;
        $display("FAIL range%0d latency: got %0d want %0d", t, o.lat, x.lat); end
      n_tests++; if (o.e !== x.e) begin n_fail++;
        $display("FAIL range%0d e: got %0h want %0h", t, o.e, x.e); end
      n_tests++; if (o.seq !== x.seq) begin n_fail++;
        $display("FAIL range%0d seq: got %0d want %0d", t, o.seq, x.seq); end
      n_tests++; if (o.count !== x.count) begin n_fail++;
        $display("FAIL range%0d count: got %0d want %0d", t, o.count, x.count); end
      n_tests++; if (o.busy_at_done !== 1'b1 || o.done_after !== 1'b0 || o.busy_after !== 1'b0)
      begin n_fail++;
        $display("FAIL range%0d handshake: got busy=%b done_next=%b busy_next=%b want 1 0 0",
                 t, o.busy_at_done, o.done_after, o.busy_after);
      end
    end
  endtask

  task automatic test_barker5;
    obs_t o;
    exp_t x;
    run(1'b1, 0, 31, 20, -1, 400, o);
    x = sb.pop_front();
    n_tests++; if (o.lat !== x.lat) begin n_fail++;
      $display("FAIL barker latency: got %0d want %0d", o.lat, x.lat); end
    n_tests++; if (o.e !== 32'd2) begin n_fail++;
      $display("FAIL barker e: got %0d want 2", o.e); end
    n_tests++; if (o.seq !== x.seq || o.count !== x.count) begin n_fail++;
      $display("FAIL barker seq/count: got %0d/%0d want %0d/%0d", o.seq, o.count, x.seq, x.count);
    end
  endtask

  task automatic test_abort;
    obs_t o;
    exp_t x;
    run(1'b0, 0, 7, -1, 9, 40, o);
    n_tests++; if (o.lat !== -1) begin n_fail++;
      $display("FAIL abort done: got pulse at %0d want none", o.lat); end
    n_tests++; if (bus3.o_busy !== 1'b0) begin n_fail++;
      $display("FAIL abort busy: got %b want 0", bus3.o_busy); end
    run(1'b0, 0, 1, -1, -1, 50, o);
    x = sb.pop_front();
    n_tests++; if (o.e !== 32'd1 || o.seq !== 32'd1 || o.count !== 32'd1) begin n_fail++;
      $display("FAIL restart result: got e=%0d seq=%0d cnt=%0d want 1 1 1", o.e, o.seq, o.count);
    end
    n_tests++; if (o.lat !== x.lat) begin n_fail++;
      $display("FAIL restart latency: got %0d want %0d", o.lat, x.lat); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus3.i_first = 3'd0; bus3.i_last = 3'd7; bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (bus3.o_busy !== 1'b0 || bus3.o_done !== 1'b0) begin n_fail++;
      $display("FAIL async busy/done: got %b/%b want 0/0", bus3.o_busy, bus3.o_done); end
    n_tests++; if (32'(bus3.o_e) !== EOnes || bus3.o_seq !== 3'd0 || bus3.o_count !== 16'd0)
    begin n_fail++;
      $display("FAIL async results: got e=%0h seq=%0d cnt=%0d want %0h 0 0",
               bus3.o_e, bus3.o_seq, bus3.o_count, EOnes);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t x;
    for (int t = 0; t < 6; t++) begin
      bit use5 = (t >= 4);
      int hi   = use5 ? 31 : 7;
      int f    = int'($urandom_range(hi, 0));
      int l    = int'($urandom_range(hi, 0));
      run(use5, f, l, -1, -1, 400, o);
      x = sb.pop_front();
      n_tests++;
      if (o.lat !== x.lat || o.e !== x.e || o.seq !== x.seq || o.count !== x.count) begin
        n_fail++;
        $display("FAIL b2b%0d %0d..%0d: got lat=%0d e=%0d seq=%0d cnt=%0d want %0d %0d %0d %0d",
                 t, f, l, o.lat, o.e, o.seq, o.count, x.lat, x.e, x.seq, x.count);
      end
    end
  endtask

  initial begin
    bus3.i_start = 1'b0; bus3.i_abort = 1'b0; bus3.i_first = '0; bus3.i_last = '0;
    bus5.i_start = 1'b0; bus5.i_abort = 1'b0; bus5.i_first = '0; bus5.i_last = '0;
    #1;
    test_reset();
    test_ranges3();
    test_barker5();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/find_range.md
Name: find_range

Overview:
- Self-contained search engine for low-autocorrelation binary sequences.
- Iterates over a programmable range of SEQ_WIDTH-bit sequences, [i_first, i_last], under a start/busy/done handshake.
- Computes each sequence's energy E with a lag-serial datapath: one lag per cycle.
- Tracks the lowest E found, the first sequence that reached it, and how many sequences share it.
- Intended as the next-generation replacement for the fixed-range search top. Multiple instances can each cover a sub-range.

Parameters:
SEQ_WIDTH, 8, sequence length N in bits; must be >= 2
E_WIDTH, 20, energy width; must be >= clog2((N-1)N(2N-1)/6 + 1)
COUNT_WIDTH, 16, width of the tie counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
i_start  input  1  start pulse; sampled only in IDLE
i_abort  input  1  abandon the current search
i_first  input  SEQ_WIDTH  first sequence of the range; latched on start
i_last  input  SEQ_WIDTH  last sequence of the range, inclusive; latched on start
o_busy  output  1  high from start acceptance until the DONE state is left
o_done  output  1  one-cycle pulse when the search completes
o_seq  output  SEQ_WIDTH  first sequence achieving the best E
o_e  output  E_WIDTH  best E found
o_count  output  COUNT_WIDTH  number of evaluated sequences with E == o_e; saturating

Behaviour:
- Reset (rst low, async):
  - state=IDLE; o_busy=0, o_done=0, o_seq=0, o_e=all-ones, o_count=0.
  - Internal counters are cleared.
- Energy definition:
  - Bit i maps to s_i = +1 if 0, -1 if 1.
  - C_k = sum over i=0..N-1-k of s_i*s_(i+k).
  - E = sum over k=1..N-1 of C_k^2.
- Lag computation:
  - d = popcount((seq ^ (seq >> k)) & mask of low N-k bits).
  - C_k = (N-k) - 2d, held signed.
  - C_k^2 is added to an unsigned accumulator.
  - Width rule: the accumulator never overflows for legal parameters.
- FSM states: IDLE, CALC, CMP, DONE.
- IDLE:
  - On i_start: latch i_first/i_last; seq <= i_first; k <= 1; acc <= 0.
  - Reset results to o_e=all-ones, o_seq=0, o_count=0.
  - o_busy <= 1.
  - If i_first > i_last, go to DONE (empty range; results stay at their reset values). Otherwise go to CALC.
- CALC:
  - Each cycle adds lag k; k increments.
  - After k = N-1, go to CMP.
  - Takes N-1 cycles.
- CMP, comparing acc against o_e:
  - acc < o_e: o_e <= acc, o_seq <= seq, o_count <= 1.
  - acc == o_e: o_count <= o_count + 1, saturating at all-ones; o_seq unchanged (first occurrence wins).
  - Then: if seq == i_last, go to DONE. Otherwise seq <= seq+1, k <= 1, acc <= 0, go to CALC.
  - seq is compared before increment, so i_last = all-ones never wraps.
- Cost per sequence: N cycles.
- DONE:
  - o_done=1 for exactly one cycle; o_busy drops next cycle; return to IDLE.
  - Results hold until the next accepted start.
- i_start while busy is ignored.
- i_abort:
  - Effective in CALC or CMP: next state IDLE, o_busy <= 0, no o_done pulse.
  - Results keep the partial best.
  - An abort in the same cycle as the final CMP wins; no done pulse.
  - i_abort in IDLE or DONE is ignored.
- Latency: a range of M sequences gives an o_done pulse M*N + 1 cycles after the start edge.
- o_e, o_seq and o_count are only guaranteed meaningful when o_done=1 or in IDLE after completion.

Optional Feature:
- Macro: FIND_SYM_SKIP_EN.
- Defined:
  - Sequences with MSB = 1 are skipped. This is complement symmetry: E(s) = E(~s).
  - A skipped sequence costs 1 cycle, spent in CMP with no compare; it is not counted in o_count.
  - Range termination and the i_last check are unchanged.
- Undefined: every sequence in the range is evaluated.

Test Plan:
- N=3, first=0, last=7, start -> o_done 25 cycles after the start edge; o_e=1, o_seq=3'b001, o_count=4 (E of sequences 0..7 = 5,1,5,1,1,5,1,5).
- N=3, first=7, last=7 -> o_e=5, o_seq=7, o_count=1, o_done after 4 cycles; no counter wrap, busy then low.
- N=3, first=5, last=2 -> o_done 1 cycle after the start edge; o_e=all-ones, o_seq=0, o_count=0.
- N=5, first=0, last=31 -> o_e=2 (Barker-5 optimum); a pulse at i_start during the run is ignored.
- N=3, range 0..7, i_abort at cycle 10 -> no o_done, o_busy=0; a new start at 0..1 gives o_e=1, o_seq=1, o_count=1. Separately, rst pulled low mid-run -> all outputs return to reset values immediately.
- FIND_SYM_SKIP_EN defined, N=3, range 0..7 -> o_done 17 cycles after the start edge; o_e=1, o_seq=1, o_count=2.
